parking_lot_multi_entry: RTL and testbench
==========================================

// Module: parking_lot_multi_entry
// PURPOSE
//  Occupancy tracker for a lot with N_ENTRY independent gates. Each gate has
//  two beam sensors: a = outer, b = inner; 1 = beam blocked.
//  Per gate, a sensor FSM decodes car-in / car-out events and illegal sequences.
//  A shared saturating counter keeps occupancy and drives full/empty status
//  for the lot signage/barrier controller.
// PARAMETERS
//  N_ENTRY   4                            number of gates (>=1)
//  CAPACITY  64                           parking spaces (>=1)
//  CNT_W     $clog2(CAPACITY+1)           width of count (derived, do not override)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset: synchronous, active-high
//  a          in   N_ENTRY  outer sensor per gate
//  b          in   N_ENTRY  inner sensor per gate
//  clr_flags  in   1        clears sticky overflow/underflow
//  in         out  N_ENTRY  car entered gate i; 1-cycle pulse
//  out        out  N_ENTRY  car left gate i; 1-cycle pulse
//  err_vec    out  N_ENTRY  gate i FSM in ERR state
//  count      out  CNT_W    cars currently inside
//  full       out  1        count == CAPACITY
//  empty      out  1        count == 0
//  overflow   out  1        sticky: an entry was lost to saturation at CAPACITY
//  underflow  out  1        sticky: an exit was lost to saturation at 0
//  error      out  1        |err_vec | overflow | underflow
// BEHAVIOUR
//  - All registers are sampled on the rising edge of clk.
//  - rst wins over everything. After reset:
//      FSMs = IDLE; in = out = err_vec = 0; count = 0; empty = 1;
//      full = overflow = underflow = error = 0.
//  - Per-gate FSM. Input is {a,b}. Any input not listed goes to ERR.
//      IDLE: 00 -> IDLE;  10 -> E1;  01 -> L1
//      E1:   10 -> E1;    11 -> E2;  00 -> IDLE (abort, no pulse)
//      E2:   11 -> E2;    01 -> E3;  10 -> E1 (car backs up)
//      E3:   01 -> E3;    00 -> IDLE and in[i] = 1 next cycle;  11 -> E2
//      L1/L2/L3 mirror E1/E2/E3 with a and b swapped.
//        L3 + 00 -> IDLE and out[i] = 1 next cycle.
//      ERR:  err_vec[i] = 1; stays in ERR until {a,b} == 00, then IDLE.
//  - in/out are registered. Pulse is high exactly the cycle after the edge
//    that samples 00 in E3/L3.
//  - Counter:
//      delta = popcount(in) - popcount(out), signed, width CNT_W+2.
//      count updates on the edge after the pulses, i.e. 1 cycle after in/out.
//      Simultaneous in and out on different gates net out in the same cycle.
//  - Saturation:
//      sum > CAPACITY -> count = CAPACITY, overflow <= 1.
//      sum < 0        -> count = 0,        underflow <= 1.
//      Gate pulses are never suppressed by full.
//  - full/empty are combinational from the count register.
//  - clr_flags clears overflow/underflow. A new saturation in the same
//    cycle as clr_flags wins (flag stays 1).
//  - Reset mid-car returns the FSM to IDLE. A sensor stuck at 11 after reset
//    sends that FSM to ERR (intended: no phantom count).
// STRUCTURE
//  - Package parking_pkg:
//      state typedef {IDLE, E1, E2, E3, L1, L2, L3, ERR}, 3-bit encoding;
//      popcount function.
//  - Sub-module parking_entry_fsm (clk, rst, a, b, in, out, err), one per gate
//    via generate.
//  - Top level: counter, saturation, sticky flags, status logic only.
// TESTING
//  1. Gate 0 sees 00,10,11,01,00 -> in[0] = 1 for one cycle; count 0 -> 1 the
//     next cycle; empty = 0.
//  2. Gate 2 sees 00,01,11,10,00 with count = 3 -> out[2] pulse; count = 2.
//  3. Gate 1 sees 10,00 (abort), then 00 -> 11 -> no pulses; err_vec[1] = 1
//     until 00; count unchanged.
//  4. CAPACITY = 64, count = 63, gates 0 and 1 complete entry in the same
//     cycle -> count = 64, full = 1, overflow = 1, error = 1; clr_flags
//     clears overflow.
//  5. Gate 0 entry and gate 3 exit complete in the same cycle with count = 5
//     -> count stays 5; both pulses seen.
//  6. rst asserted while gate 0 is in E2 with sensors at 11 -> next cycle
//     count = 0, then gate 0 goes to ERR; release to 00 -> IDLE; no pulse.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-gate parking lot occupancy tracker.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        L1   = 3'd4,
        L2   = 3'd5,
        L3   = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam int unsigned MAX_GATES = 32;
    localparam int unsigned POP_W     = 6;

    // Number of set bits in a gate-pulse vector, zero-extended to MAX_GATES.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_GATES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_GATES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_entry_fsm.sv
// Per-gate beam-sensor decoder: turns the a/b blocking order into entry/exit pulses.
module parking_entry_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic in,
    output logic out,
    output logic err
);

    state_t state, state_nxt;
    logic   in_nxt, out_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in    <= 1'b0;
            out   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            in    <= in_nxt;
            out   <= out_nxt;
            err   <= (state_nxt == ERR);
        end
    end

    // Any sensor pattern not explicitly accepted falls through to ERR.
    always_comb begin
        state_nxt = ERR;
        in_nxt    = 1'b0;
        out_nxt   = 1'b0;
        case (state)
            IDLE: case ({a, b})
                2'b00:   state_nxt = IDLE;
                2'b10:   state_nxt = E1;
                2'b01:   state_nxt = L1;
                default: state_nxt = ERR;
            endcase
            E1: case ({a, b})
                2'b10:   state_nxt = E1;
                2'b11:   state_nxt = E2;
                2'b00:   state_nxt = IDLE;
                default: state_nxt = ERR;
            endcase
            E2: case ({a, b})
                2'b11:   state_nxt = E2;
                2'b01:   state_nxt = E3;
                2'b10:   state_nxt = E1;
                default: state_nxt = ERR;
            endcase
            E3: case ({a, b})
                2'b01:   state_nxt = E3;
                2'b00: begin
                    state_nxt = IDLE;
                    in_nxt    = 1'b1;
                end
                2'b11:   state_nxt = E2;
                default: state_nxt = ERR;
            endcase
            L1: case ({a, b})
                2'b01:   state_nxt = L1;
                2'b11:   state_nxt = L2;
                2'b00:   state_nxt = IDLE;
                default: state_nxt = ERR;
            endcase
            L2: case ({a, b})
                2'b11:   state_nxt = L2;
                2'b10:   state_nxt = L3;
                2'b01:   state_nxt = L1;
                default: state_nxt = ERR;
            endcase
            L3: case ({a, b})
                2'b10:   state_nxt = L3;
                2'b00: begin
                    state_nxt = IDLE;
                    out_nxt   = 1'b1;
                end
                2'b11:   state_nxt = L2;
                default: state_nxt = ERR;
            endcase
            ERR:     state_nxt = ({a, b} == 2'b00) ? IDLE : ERR;
            default: state_nxt = ERR;
        endcase
    end

endmodule

// File: rtl/parking_lot_multi_entry.sv
// Lot occupancy tracker: per-gate decoders feeding a shared saturating counter.
module parking_lot_multi_entry
    import parking_pkg::*;
#(
    parameter  int unsigned N_ENTRY  = 4,
    parameter  int unsigned CAPACITY = 64,
    localparam int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ENTRY-1:0] a,
    input  logic [N_ENTRY-1:0] b,
    input  logic               clr_flags,
    output logic [N_ENTRY-1:0] in,
    output logic [N_ENTRY-1:0] out,
    output logic [N_ENTRY-1:0] err_vec,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow,
    output logic               error
);

    localparam int unsigned SUM_W = CNT_W + 2;

    logic signed [SUM_W-1:0] delta;
    logic signed [SUM_W-1:0] sum;
    logic                    sat_hi;
    logic                    sat_lo;

    for (genvar g = 0; g < N_ENTRY; g++) begin : g_gate
        parking_entry_fsm u_fsm (
            .clk (clk),
            .rst (rst),
            .a   (a[g]),
            .b   (b[g]),
            .in  (in[g]),
            .out (out[g]),
            .err (err_vec[g])
        );
    end

    // Entries and exits on different gates in the same cycle net out here.
    always_comb begin
        delta  = $signed(SUM_W'(popcount(MAX_GATES'(in))))
               - $signed(SUM_W'(popcount(MAX_GATES'(out))));
        sum    = $signed(SUM_W'(count)) + delta;
        sat_hi = (sum > $signed(SUM_W'(CAPACITY)));
        sat_lo = (sum < $signed(SUM_W'(0)));
    end

    // A fresh saturation outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (sat_hi) begin
                count <= CNT_W'(CAPACITY);
            end else if (sat_lo) begin
                count <= '0;
            end else begin
                count <= CNT_W'(sum);
            end
            overflow  <= sat_hi | (overflow & ~clr_flags);
            underflow <= sat_lo | (underflow & ~clr_flags);
        end
    end

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);
    assign error = (|err_vec) | overflow | underflow;

endmodule

// File: tb/tb_parking_lot_multi_entry.sv
// Directed bench for parking_lot_multi_entry with hand-computed expectations.
module tb_parking_lot_multi_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'b0;
    logic [3:0] b = 4'b0;
    logic       clr_flags = 1'b0;
    logic [3:0] ins, outs, err_vec;
    logic [6:0] count;
    logic       full, empty, overflow, underflow, error;

    int total = 0;
    int bad   = 0;

    parking_lot_multi_entry #(.N_ENTRY(4), .CAPACITY(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .clr_flags (clr_flags),
        .in        (ins),
        .out       (outs),
        .err_vec   (err_vec),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
    endtask

    // Full pass on masked gates: em gates walk an entry, xm gates walk an exit.
    task automatic gate_seq(input logic [3:0] em, input logic [3:0] xm);
        logic sa, sb;
        for (int k = 0; k < 5; k++) begin
            case (k)
                1:       begin sa = 1'b1; sb = 1'b0; end
                2:       begin sa = 1'b1; sb = 1'b1; end
                3:       begin sa = 1'b0; sb = 1'b1; end
                default: begin sa = 1'b0; sb = 1'b0; end
            endcase
            drive(({4{sa}} & em) | ({4{sb}} & xm), ({4{sb}} & em) | ({4{sa}} & xm));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_flags", int'({overflow, underflow, error}), 0);
        check("rst_pulses", int'({ins, outs, err_vec}), 0);

        // single entry on gate 0
        gate_seq(4'b0001, 4'b0000);
        @(negedge clk);
        check("t1_in", int'(ins), 1);
        check("t1_count_lag", int'(count), 0);
        @(negedge clk);
        check("t1_in_drop", int'(ins), 0);
        check("t1_count", int'(count), 1);
        check("t1_empty", int'(empty), 0);

        gate_seq(4'b0110, 4'b0000);
        repeat (2) @(negedge clk);
        check("t2_pre_count", int'(count), 3);

        // exit on gate 2
        gate_seq(4'b0000, 4'b0100);
        @(negedge clk);
        check("t2_out", int'(outs), 4);
        @(negedge clk);
        check("t2_count", int'(count), 2);
        check("t2_out_drop", int'(outs), 0);

        // abort, then illegal 11 from IDLE on gate 1
        drive(4'b0010, 4'b0000);
        drive(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000);
        drive(4'b0010, 4'b0010);
        @(negedge clk);
        check("t3_err_vec", int'(err_vec), 2);
        check("t3_error", int'(error), 1);
        check("t3_no_pulse", int'({ins, outs}), 0);
        drive(4'b0000, 4'b0000);
        check("t3_err_hold", int'(err_vec), 2);
        @(negedge clk);
        check("t3_err_clear", int'(err_vec), 0);
        check("t3_error_clear", int'(error), 0);
        check("t3_count", int'(count), 2);

        gate_seq(4'b0111, 4'b0000);
        repeat (2) @(negedge clk);
        check("t5_pre_count", int'(count), 5);

        // simultaneous entry on gate 0 and exit on gate 3
        gate_seq(4'b0001, 4'b1000);
        @(negedge clk);
        check("t5_in", int'(ins), 1);
        check("t5_out", int'(outs), 8);
        @(negedge clk);
        check("t5_count", int'(count), 5);

        // fill to 63: 14 rounds of 4 plus 2
        repeat (14) gate_seq(4'b1111, 4'b0000);
        gate_seq(4'b0011, 4'b0000);
        repeat (2) @(negedge clk);
        check("t4_pre_count", int'(count), 63);
        check("t4_pre_full", int'(full), 0);
        gate_seq(4'b0011, 4'b0000);
        @(negedge clk);
        check("t4_in", int'(ins), 3);
        @(negedge clk);
        check("t4_count", int'(count), 64);
        check("t4_full", int'(full), 1);
        check("t4_overflow", int'(overflow), 1);
        check("t4_error", int'(error), 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("t4_ovf_clr", int'(overflow), 0);
        check("t4_err_clr", int'(error), 0);
        check("t4_full_hold", int'(full), 1);

        // reset while gate 0 sits in E2 with both beams blocked
        drive(4'b0001, 4'b0000);
        drive(4'b0001, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_count", int'(count), 0);
        check("t6_empty", int'(empty), 1);
        check("t6_err_rst", int'(err_vec), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_err", int'(err_vec), 1);
        drive(4'b0000, 4'b0000);
        @(negedge clk);
        check("t6_err_clear", int'(err_vec), 0);
        check("t6_no_pulse", int'({ins, outs}), 0);
        check("t6_count_hold", int'(count), 0);

        // exit at empty, with clr_flags in the saturating cycle
        gate_seq(4'b0000, 4'b1000);
        @(negedge clk);
        check("uf_out", int'(outs), 8);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("uf_flag", int'(underflow), 1);
        check("uf_count", int'(count), 0);
        check("uf_error", int'(error), 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("uf_clr", int'(underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
